// File: rtl/definitions.sv
// ---------------------------------------------------------------------------
// definitions
// Shared types and constants for the data memory arbiter.
//   arb_port_t    : identifies a requester (core load/store or data loader)
//   kARB_BURST_W  : width of the lock burst counter
// ---------------------------------------------------------------------------
package definitions;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_LOAD = 1'b1
    } arb_port_t;

    localparam int kARB_BURST_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin grant generator. Grants are combinational; the
// pointer to the most recently granted port is registered.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   i_req0 / i_req1     : requests
//   i_pri_valid         : force priority to i_pri_port on contention
//   i_pri_port          : port favoured while i_pri_valid is high
//   o_gnt0 / o_gnt1     : one-hot-or-zero grants
// ---------------------------------------------------------------------------
module rr_arbiter2
    import definitions::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_req0,
    input  logic      i_req1,
    input  logic      i_pri_valid,
    input  arb_port_t i_pri_port,
    output logic      o_gnt0,
    output logic      o_gnt1
);

    arb_port_t r_last;
    arb_port_t w_winner;

    always_comb begin
        w_winner = (r_last == PORT_CORE) ? PORT_LOAD : PORT_CORE;
        if (i_pri_valid) begin
            w_winner = i_pri_port;
        end
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_req0 && i_req1) begin
            o_gnt0 = (w_winner == PORT_CORE);
            o_gnt1 = (w_winner == PORT_LOAD);
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

    // Reset to PORT_LOAD so the core wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_LOAD;
        end else if (o_gnt0) begin
            r_last <= PORT_CORE;
        end else if (o_gnt1) begin
            r_last <= PORT_LOAD;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single-port data memory between the core load/store port
// (port 0) and the loader/DMA port (port 1). One access per cycle, round-robin
// on contention, read data returned registered one cycle after the grant.
// Optional feature macro: MEM_ARB_LOCK_EN (lock + bounded burst ownership).
// Ports:
//   CLK, reset_n                      : clock, async active-low reset
//   req*/we*/addr*/wdata*/lock*       : requester inputs
//   gnt*, rvalid*, rdata, core_stall  : requester outputs
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata : memory pins
// ---------------------------------------------------------------------------
module data_mem_arbiter
    import definitions::*;
#(
    parameter int MAX_BURST = 4,
    parameter int W         = 8
) (
    input  logic         CLK,
    input  logic         reset_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [W-1:0] addr0,
    input  logic [W-1:0] addr1,
    input  logic [W-1:0] wdata0,
    input  logic [W-1:0] wdata1,
    input  logic         lock0,
    input  logic         lock1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [W-1:0] rdata,
    output logic         core_stall,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    output logic         mem_read,
    output logic         mem_write,
    input  logic [W-1:0] mem_rdata
);

    logic         w_pri_valid;
    arb_port_t    w_pri_port;
    logic         r_rvalid0;
    logic         r_rvalid1;
    logic [W-1:0] r_rdata;

    rr_arbiter2 u_rr_arbiter2 (
        .clk         (CLK),
        .rst_n       (reset_n),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_pri_valid (w_pri_valid),
        .i_pri_port  (w_pri_port),
        .o_gnt0      (gnt0),
        .o_gnt1      (gnt1)
    );

`ifdef MEM_ARB_LOCK_EN
    localparam logic [kARB_BURST_W-1:0] LP_MAX_BURST = kARB_BURST_W'(MAX_BURST);

    logic                    r_own_valid;
    arb_port_t               r_owner;
    logic [kARB_BURST_W-1:0] r_burst_cnt;
    logic                    w_own_req;
    arb_port_t               w_gnt_port;
    logic                    w_gnt_lock;
    logic [kARB_BURST_W-1:0] w_burst_next;

    always_comb begin
        w_own_req    = (r_owner == PORT_CORE) ? (req0 & lock0) : (req1 & lock1);
        w_pri_valid  = r_own_valid & w_own_req;
        w_pri_port   = r_owner;
        w_gnt_port   = gnt1 ? PORT_LOAD : PORT_CORE;
        w_gnt_lock   = gnt1 ? lock1 : lock0;
        w_burst_next = kARB_BURST_W'(1);
        if (r_own_valid && (r_owner == w_gnt_port)) begin
            w_burst_next = r_burst_cnt + kARB_BURST_W'(1);
        end
    end

    // Ownership persists only while the owner is granted with lock held;
    // any other cycle (idle, lock dropped, other port granted) releases it.
    // Reaching the burst limit releases too, and since the pointer then points
    // at the owner, the other port wins the next contention.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_own_valid <= 1'b0;
            r_owner     <= PORT_CORE;
            r_burst_cnt <= '0;
        end else if ((gnt0 || gnt1) && w_gnt_lock) begin
            if (w_burst_next == LP_MAX_BURST) begin
                r_own_valid <= 1'b0;
                r_burst_cnt <= '0;
            end else begin
                r_own_valid <= 1'b1;
                r_owner     <= w_gnt_port;
                r_burst_cnt <= w_burst_next;
            end
        end else begin
            r_own_valid <= 1'b0;
            r_burst_cnt <= '0;
        end
    end
`else
    logic w_unused_cfg;

    assign w_pri_valid  = 1'b0;
    assign w_pri_port   = PORT_CORE;
    assign w_unused_cfg = lock0 ^ lock1 ^ (MAX_BURST == 0);
`endif

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign mem_write  = (gnt0 & we0) | (gnt1 & we1);
    assign mem_read   = (gnt0 & ~we0) | (gnt1 & ~we1);
    assign core_stall = req0 & ~gnt0;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid0 <= gnt0 & ~we0;
            r_rvalid1 <= gnt1 & ~we1;
            if (mem_read) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam int W         = 8;
    localparam int MAX_BURST = 4;

    logic         CLK = 1'b0;
    logic         reset_n;
    logic         req0, req1, we0, we1, lock0, lock1;
    logic [W-1:0] addr0, addr1, wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1, core_stall;
    logic [W-1:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic         mem_read, mem_write;

    logic [W-1:0] mem [256];

    data_mem_arbiter #(.MAX_BURST(MAX_BURST), .W(W)) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .lock0      (lock0),
        .lock1      (lock1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .rvalid0    (rvalid0),
        .rvalid1    (rvalid1),
        .rdata      (rdata),
        .core_stall (core_stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    // memory model: combinational read, write on clock edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int port;
        int data;
        int cyc;
    } exp_t;

    exp_t q_gnt[$];
    exp_t q_rd[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_gnt(input int port);
        exp_t e;
        e.port = port; e.data = 0; e.cyc = cyc;
        q_gnt.push_back(e);
    endtask

    task automatic push_rd(input int port, input int data);
        exp_t e;
        e.port = port; e.data = data; e.cyc = cyc + 1;
        q_rd.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                         input logic l0, input logic l1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    endtask

    // monitor: pops expectations whenever the DUT presents a grant or rvalid
    always @(negedge CLK) begin
        if (reset_n) begin
            exp_t e;
            if (gnt0 && gnt1) begin
                chk("gnt_onehot", 1, 0);
            end else if (gnt0 || gnt1) begin
                if (q_gnt.size() == 0) begin
                    chk("unexpected_gnt", gnt1 ? 1 : 0, -1);
                end else begin
                    e = q_gnt.pop_front();
                    chk("gnt_port", gnt1 ? 1 : 0, e.port);
                    chk("gnt_cycle", cyc, e.cyc);
                end
            end
            if (rvalid0 && rvalid1) begin
                chk("rvalid_onehot", 1, 0);
            end else if (rvalid0 || rvalid1) begin
                if (q_rd.size() == 0) begin
                    chk("unexpected_rvalid", rvalid1 ? 1 : 0, -1);
                end else begin
                    e = q_rd.pop_front();
                    chk("rvalid_port", rvalid1 ? 1 : 0, e.port);
                    chk("rdata", int'(rdata), e.data);
                    chk("rvalid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    int lock_exp[4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hA5;
        mem[8'h30] = 8'h5C;
        mem[8'h40] = 8'h3C;
        mem[8'h41] = 8'hC3;
        reset_n = 1'b0;
        idle();
        #12 reset_n = 1'b1;
        #1;
        chk("rst_gnt0", int'(gnt0), 0);
        chk("rst_gnt1", int'(gnt1), 0);
        chk("rst_rvalid0", int'(rvalid0), 0);
        chk("rst_rvalid1", int'(rvalid1), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_mem_read", int'(mem_read), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_stall", int'(core_stall), 0);
        next_cycle();

        // port-0 read after reset
        drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        push_gnt(0); push_rd(0, 8'hA5);
        #2;
        chk("rd0_stall", int'(core_stall), 0);
        chk("rd0_mem_read", int'(mem_read), 1);
        chk("rd0_mem_addr", int'(mem_addr), 8'h10);
        next_cycle();
        idle();
        next_cycle();

        // reset while a port-1 read response is pending
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0, 0);
        push_gnt(1);
        next_cycle();
        chk("pend_rvalid1", int'(rvalid1), 1);
        chk("pend_rdata", int'(rdata), 8'h5C);
        idle();
        reset_n = 1'b0;
        #1;
        chk("rst_mid_rvalid1", int'(rvalid1), 0);
        chk("rst_mid_rdata", int'(rdata), 0);
        #1 reset_n = 1'b1;
        next_cycle();

        // contention: both write continuously, grants alternate from port 0
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h20, 8'h11, 1, 1, 8'h21, 8'h22, 0, 0);
            push_gnt(i % 2);
            #2;
            chk("cont_stall", int'(core_stall), (i % 2 == 1) ? 1 : 0);
            next_cycle();
        end
        idle();
        chk("mem_20", int'(mem[8'h20]), 8'h11);
        chk("mem_21", int'(mem[8'h21]), 8'h22);

        // port-0 grant, three idle cycles, then contention goes to port 1
        drive(1, 1, 8'h50, 8'h77, 0, 0, 8'h00, 8'h00, 0, 0);
        push_gnt(0);
        next_cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("idle_mem_read", int'(mem_read), 0);
            chk("idle_mem_write", int'(mem_write), 0);
            chk("idle_mem_addr", int'(mem_addr), 0);
            next_cycle();
        end
        drive(1, 1, 8'h51, 8'h01, 1, 1, 8'h52, 8'h02, 0, 0);
        push_gnt(1);
        #2;
        chk("post_idle_stall", int'(core_stall), 1);
        next_cycle();
        drive(1, 1, 8'h51, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0);
        push_gnt(0);
        #2;
        chk("held_req_stall", int'(core_stall), 0);
        next_cycle();
        idle();
        chk("mem_50", int'(mem[8'h50]), 8'h77);
        chk("mem_52", int'(mem[8'h52]), 8'h02);

        // back-to-back reads from different ports
        drive(1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
        push_gnt(0); push_rd(0, 8'h3C);
        next_cycle();
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h41, 8'h00, 0, 0);
        push_gnt(1); push_rd(1, 8'hC3);
        next_cycle();
        idle();
        next_cycle();
        next_cycle();

        // lock: port 1 takes ownership, then both request
`ifdef MEM_ARB_LOCK_EN
        lock_exp = '{1, 1, 1, 0};
`else
        lock_exp = '{0, 1, 0, 1};
`endif
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h60, 8'h09, 0, 1);
        push_gnt(1);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h61, 8'h0A, 1, 1, 8'h62, 8'h0B, 0, 1);
            push_gnt(lock_exp[i]);
            next_cycle();
        end
        idle();
        next_cycle();
        next_cycle();

        chk("gnt_queue_empty", q_gnt.size(), 0);
        chk("rd_queue_empty", q_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port 8-bit data memory between two requesters: the core load/store port (port 0) and the data loader/DMA port (port 1). It arbitrates one access per cycle with round-robin priority, drives the data memory address, data and enable pins, and returns read data one cycle after each grant. It also produces the core stall signal. It sits between the core's load/store decode and the data memory instance.

## Interface
- `MAX_BURST`, default 4: maximum consecutive grants to one locked port before a forced hand-over. Range 1–15.
- `W`, default 8: data and address width.
- `CLK` in 1: clock, posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0` / `req1` in 1: access request from port 0 (core) / port 1 (loader).
- `we0` / `we1` in 1: 1 = write, 0 = read.
- `addr0` / `addr1` in W: memory address.
- `wdata0` / `wdata1` in W: write data.
- `lock0` / `lock1` in 1: hold the grant for consecutive accesses. Only used when lock is compiled in.
- `gnt0` / `gnt1` out 1: access accepted this cycle.
- `rvalid0` / `rvalid1` out 1: read data valid for that port.
- `rdata` out W: registered read data, shared by both ports.
- `core_stall` out 1: equals `req0 & ~gnt0`.
- `mem_addr` out W: to data memory DataAddress.
- `mem_wdata` out W: to data memory DataIn.
- `mem_read` / `mem_write` out 1: to data memory ReadMem / WriteMem.
- `mem_rdata` in W: data memory DataOut. Combinational with respect to `mem_addr`.

## Operation
- **Arbitration state:** a priority pointer `last` (0/1) holds the port granted most recently.
  - The other port has priority when both ports request.
  - A single requester is always granted.
- **Grant logic:** grants are combinational from the requests and registered state, and are one-hot or zero.
- **Memory pins when granted:**
  - `mem_addr` and `mem_wdata` are muxed from the granted port.
  - `mem_write` = `gnt & we`.
  - `mem_read` = `gnt & ~we`.
- **Memory pins when idle:** `mem_read` = `mem_write` = 0, and `mem_addr` / `mem_wdata` hold 0.
- **Read response:**
  - On a granted read, `mem_rdata` is captured into `rdata`.
  - `rvalid` of that port is asserted for exactly the next cycle.
  - `rdata` holds its value until the next granted read.
- **Writes:** complete in the grant cycle. No response is generated.
- **Pointer update:** `last` updates on every cycle with a grant. It is unchanged on idle cycles.
- **Reset values:**
  - `last` = 1, so port 0 wins the first contention.
  - `rdata` = 0, `rvalid0` = `rvalid1` = 0.
  - Burst counter = 0, lock owner = none.
  - All `mem_*` outputs are 0, and `gnt*` = 0 with no requests.
- **Reset mid-operation:** an asserted `reset_n` immediately clears any pending `rvalid` and the lock state. An in-flight read response is dropped.

## Timing
- Request to grant: 0 cycles, same cycle.
- Grant to memory access: same cycle.
- Read grant to `rvalid` / `rdata`: 1 cycle.
- **Request-holding rule:**
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - `req` may drop after the grant cycle.
  - A requester must not treat a read as complete before its `rvalid`.
- **Back-to-back:** both ports requesting every cycle alternate grants: 0, 1, 0, 1, …
- **Simultaneous read:** if port 0 reads in cycle N and port 1 reads in cycle N+1, then `rvalid0` is asserted in N+1 and `rvalid1` in N+2, each with its own data.
- **Throughput:** one access per cycle in total. Zero idle cycles under continuous requests.

## Configuration
- **`MEM_ARB_LOCK_EN` defined:**
  - A granted port with its `lock` high becomes the lock owner.
  - The owner keeps priority while it requests with `lock` high.
  - A 4-bit burst counter increments per owner grant.
  - When the counter reaches `MAX_BURST`, ownership is released, the counter clears, and the other port wins the next contention.
  - Ownership also releases when the owner drops `lock`, or drops `req` for a cycle.
- **`MEM_ARB_LOCK_EN` undefined:**
  - `lock0` / `lock1` are ignored.
  - No counter or owner registers exist.
  - Arbitration is pure round-robin.

## Structure
- **Shared package `definitions`:**
  - typedef `arb_port_t` (enum: `PORT_CORE` = 0, `PORT_LOAD` = 1).
  - Constant `kARB_BURST_W` = 4.
- **Sub-module `rr_arbiter2`:** a 2-input round-robin grant generator with `last` pointer update. The lock and burst logic and the datapath muxing stay in `data_mem_arbiter`.
- No other sub-modules.

## Test plan
- **Reset then port-0 read:** `reset_n` low, then high; `req0` = 1, `we0` = 0, `addr0` = 0x10, memory [0x10] = 0xA5.
  - `gnt0` = 1 in the same cycle.
  - `rvalid0` = 1 and `rdata` = 0xA5 on the next cycle.
  - `core_stall` = 0.
- **Contention:** both ports request writes continuously; port 0 writes 0x11 to 0x20, port 1 writes 0x22 to 0x21.
  - Grants go 0, 1, 0, 1.
  - `core_stall` = 1 on the port-1 cycles.
  - Memory ends with [0x20] = 0x11 and [0x21] = 0x22.
- **Idle cycles:** no requests for 3 cycles.
  - `mem_read` = `mem_write` = 0.
  - `last` is unchanged; the next contention goes to the port not granted most recently.
- **Lock (`MEM_ARB_LOCK_EN`, `MAX_BURST` = 4):** `lock1` = 1, both ports requesting.
  - Port 1 gets 4 consecutive grants.
  - Port 0 gets the 5th grant.
- **Reset during a pending read:** `reset_n` pulses low in the cycle after a port-1 read grant.
  - `rvalid1` = 0 immediately.
  - `rdata` = 0.
- **Back-to-back reads:** port 0 reads in cycle N, port 1 reads in cycle N+1, to different addresses.
  - `rvalid0` = 1 in N+1 with its own data.
  - `rvalid1` = 1 in N+2 with its own data.
